mem_bus_responder: RTL and testbench

Memory-side end of the data bus that the memory bus arbiter grants to L2 or DSC. It samples the bus enable and rw lines, runs wrapping bursts against the synchronous external SRAM port with programmable wait states, and drives the status_bus_transmitting line the arbiter uses to close a grant early. It guarantees that a transfer ends within 3 cycles of enable dropping, which fits inside the arbiter's 4-cycle hand-over window.

---
 rtl/mem_bus_responder.sv | 156 +++++++++++++++
 tb/tb_mem_bus_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - memory-side bus responder running wrapping SRAM bursts with wait states.
// Optional protocol error flag enabled by defining MEM_BUS_RESPONDER_ERR_EN.
module mem_bus_responder #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 32,
    parameter int BURST_LEN   = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk_166M66,
    input  logic              mcu_sys_rst,
    input  logic              i_data_bus_enable,
    input  logic              i_data_bus_rw,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_wdata_ready,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rdata_valid,
    output logic              o_status_bus_transmitting,
    output logic              o_mem_ce,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_bus_err
);

    localparam int               BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [1:0]        WAIT_INIT = 2'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] base, base_d;
    logic              rw_q, rw_d;
    logic [BEAT_W-1:0] beat, beat_d;
    logic [1:0]        wait_cnt, wait_d;
    logic              beat_start;
    logic              rd_capture;
    logic              access_d;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        state_d    = state;
        base_d     = base;
        rw_d       = rw_q;
        beat_d     = beat;
        wait_d     = wait_cnt;
        beat_start = 1'b0;
        rd_capture = 1'b0;
        case (state)
            IDLE: begin
                if (i_data_bus_enable) begin
                    base_d     = i_addr;
                    rw_d       = i_data_bus_rw;
                    beat_d     = '0;
                    wait_d     = WAIT_INIT;
                    beat_start = 1'b1;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (wait_cnt == 2'd0) begin
                    rd_capture = ~rw_q;
                    // A beat is never cut short; enable/rw are only judged at its last cycle.
                    if (beat == LAST_BEAT) begin
                        state_d = DONE;
                    end else if (i_data_bus_enable && (i_data_bus_rw == rw_q)) begin
                        beat_d     = beat + 1'b1;
                        wait_d     = WAIT_INIT;
                        beat_start = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    wait_d = wait_cnt - 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        access_d = (state_d == ACCESS);
        // Wrap only the low beat bits; upper address bits stay fixed for the whole burst.
        addr_d                = base_d;
        addr_d[BEAT_W-1:0]    = base_d[BEAT_W-1:0] + beat_d;
    end

    always_ff @(posedge clk_166M66) begin
        if (mcu_sys_rst) begin
            state                     <= IDLE;
            base                      <= '0;
            rw_q                      <= 1'b0;
            beat                      <= '0;
            wait_cnt                  <= 2'd0;
            o_status_bus_transmitting <= 1'b0;
            o_mem_ce                  <= 1'b0;
            o_mem_we                  <= 1'b0;
            o_mem_addr                <= '0;
            o_mem_wdata               <= '0;
            o_wdata_ready             <= 1'b0;
            o_rdata                   <= '0;
            o_rdata_valid             <= 1'b0;
        end else begin
            state                     <= state_d;
            base                      <= base_d;
            rw_q                      <= rw_d;
            beat                      <= beat_d;
            wait_cnt                  <= wait_d;
            o_status_bus_transmitting <= access_d;
            o_mem_ce                  <= access_d;
            o_mem_we                  <= access_d & rw_d;
            o_mem_addr                <= access_d ? addr_d : '0;
            o_wdata_ready             <= beat_start & rw_d;
            if (beat_start && rw_d) begin
                o_mem_wdata <= i_wdata;
            end
            o_rdata_valid <= rd_capture;
            if (rd_capture) begin
                o_rdata <= i_mem_rdata;
            end
        end
    end

`ifdef MEM_BUS_RESPONDER_ERR_EN
    logic en_q;
    logic rw_err;
    logic addr_err;

    assign rw_err = (state == ACCESS) && i_data_bus_enable && (i_data_bus_rw != rw_q);
`ifndef SYNTHESIS
    assign addr_err = i_data_bus_enable && !en_q && $isunknown(i_addr);
`else
    assign addr_err = 1'b0;
`endif

    always_ff @(posedge clk_166M66) begin
        if (mcu_sys_rst) begin
            en_q      <= 1'b0;
            o_bus_err <= 1'b0;
        end else begin
            en_q <= i_data_bus_enable;
            if (rw_err || addr_err) begin
                o_bus_err <= 1'b1;
            end
        end
    end
`else
    assign o_bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - directed vector bench for mem_bus_responder with SRAM model.
module tb_mem_bus_responder;

    localparam int ADDR_W      = 24;
    localparam int DATA_W      = 32;
    localparam int BURST_LEN   = 4;
    localparam int WAIT_CYCLES = 2;
`ifdef MEM_BUS_RESPONDER_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic              clk_166M66 = 1'b0;
    logic              mcu_sys_rst;
    logic              i_data_bus_enable;
    logic              i_data_bus_rw;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic              o_wdata_ready;
    logic [DATA_W-1:0] o_rdata;
    logic              o_rdata_valid;
    logic              o_status_bus_transmitting;
    logic              o_mem_ce;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              o_bus_err;

    always #3 clk_166M66 = ~clk_166M66;

    mem_bus_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk_166M66(clk_166M66),
        .mcu_sys_rst(mcu_sys_rst),
        .i_data_bus_enable(i_data_bus_enable),
        .i_data_bus_rw(i_data_bus_rw),
        .i_addr(i_addr),
        .i_wdata(i_wdata),
        .o_wdata_ready(o_wdata_ready),
        .o_rdata(o_rdata),
        .o_rdata_valid(o_rdata_valid),
        .o_status_bus_transmitting(o_status_bus_transmitting),
        .o_mem_ce(o_mem_ce),
        .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata),
        .o_bus_err(o_bus_err)
    );

    // SRAM model: preloaded with 0x5500_00xx, combinational read, write on ce&we.
    logic [31:0] mem [256];
    logic        preload;
    always @(posedge clk_166M66) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h5500_0000 + i;
        end else if (o_mem_ce && o_mem_we) begin
            mem[o_mem_addr[7:0]] <= o_mem_wdata;
        end
    end
    assign i_mem_rdata = mem[o_mem_addr[7:0]];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic             rw;
        logic [23:0]      addr;
        int               drop_k;
        int               nb;
        logic [3:0][23:0] exp_addr;
        logic [3:0][31:0] wdata;
    } vec_t;

    function automatic vec_t mk(input logic rw, input logic [23:0] addr, input int drop_k, input int nb,
                                input logic [23:0] a0, input logic [23:0] a1, input logic [23:0] a2,
                                input logic [23:0] a3, input logic [31:0] d0);
        vec_t v;
        v.rw = rw; v.addr = addr; v.drop_k = drop_k; v.nb = nb;
        v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2; v.exp_addr[3] = a3;
        for (int i = 0; i < 4; i++) v.wdata[i] = d0 + 32'(i);
        return v;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, " tx"},     32'(o_status_bus_transmitting), 32'd0);
        check({tag, " ce"},     32'(o_mem_ce), 32'd0);
        check({tag, " we"},     32'(o_mem_we), 32'd0);
        check({tag, " addr"},   32'(o_mem_addr), 32'd0);
        check({tag, " mwdata"}, o_mem_wdata, 32'd0);
        check({tag, " wready"}, 32'(o_wdata_ready), 32'd0);
        check({tag, " rdata"},  o_rdata, 32'd0);
        check({tag, " rvalid"}, 32'(o_rdata_valid), 32'd0);
        check({tag, " err"},    32'(o_bus_err), 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int    widx;
        int    b;
        logic  exp_tx;
        logic  exp_vld;
        string t;
        widx = 0;
        i_addr = v.addr;
        i_data_bus_rw = v.rw;
        i_wdata = v.wdata[0];
        i_data_bus_enable = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            @(posedge clk_166M66); #1;
            t = $sformatf("v%0d k%0d", idx, k);
            b = k / 3;
            exp_tx  = (k < 3 * v.nb);
            exp_vld = !v.rw && (k > 0) && (k % 3 == 0) && (b <= v.nb);
            check({t, " tx"}, 32'(o_status_bus_transmitting), 32'(exp_tx));
            check({t, " ce"}, 32'(o_mem_ce), 32'(exp_tx));
            check({t, " we"}, 32'(o_mem_we), 32'(exp_tx & v.rw));
            check({t, " wready"}, 32'(o_wdata_ready), 32'(v.rw && (k % 3 == 0) && (b < v.nb)));
            check({t, " rvalid"}, 32'(o_rdata_valid), 32'(exp_vld));
            if (exp_tx) check({t, " addr"}, 32'(o_mem_addr), 32'(v.exp_addr[b]));
            if (exp_tx && v.rw) check({t, " mwdata"}, o_mem_wdata, v.wdata[b]);
            if (exp_vld) check({t, " rdata"}, o_rdata, 32'h5500_0000 + 32'(v.exp_addr[b-1][7:0]));
            if (o_wdata_ready && widx < 3) begin
                widx++;
                i_wdata = v.wdata[widx];
            end
            if (k == v.drop_k) i_data_bus_enable = 1'b0;
        end
        if (v.rw) begin
            for (int i = 0; i < 4; i++) begin
                t = $sformatf("v%0d mem[%0d]", idx, i);
                if (i < v.nb) check(t, mem[v.exp_addr[i][7:0]], v.wdata[i]);
                else          check(t, mem[v.exp_addr[i][7:0]], 32'h5500_0000 + 32'(v.exp_addr[i][7:0]));
            end
        end
    endtask

    vec_t vecs [6];
    int   n_tx;
    int   n_vld;

    initial begin
        vecs[0] = mk(1'b0, 24'h000010, 11, 4, 24'h10, 24'h11, 24'h12, 24'h13, 32'h0);
        vecs[1] = mk(1'b1, 24'h000020, 11, 4, 24'h20, 24'h21, 24'h22, 24'h23, 32'hA0);
        vecs[2] = mk(1'b0, 24'h000012, 11, 4, 24'h12, 24'h13, 24'h10, 24'h11, 32'h0);
        vecs[3] = mk(1'b0, 24'h000035,  4, 2, 24'h35, 24'h36, 24'h37, 24'h34, 32'h0);
        vecs[4] = mk(1'b0, 24'hABCDEF, 11, 4, 24'hABCDEF, 24'hABCDEC, 24'hABCDED, 24'hABCDEE, 32'h0);
        vecs[5] = mk(1'b1, 24'h00003E,  7, 3, 24'h3E, 24'h3F, 24'h3C, 24'h3D, 32'hB0);

        mcu_sys_rst = 1'b1;
        preload = 1'b1;
        i_data_bus_enable = 1'b0;
        i_data_bus_rw = 1'b0;
        i_addr = '0;
        i_wdata = '0;
        repeat (3) @(posedge clk_166M66);
        #1;
        check_zero("reset");
        mcu_sys_rst = 1'b0;
        preload = 1'b0;
        repeat (2) @(posedge clk_166M66);
        #1;

        for (int v = 0; v < 6; v++) run_vec(v, vecs[v]);

        // rw flips mid-burst with enable high: beat 1 completes, burst ends, error flag per build.
        check("err before", 32'(o_bus_err), 32'd0);
        n_tx = 0;
        n_vld = 0;
        i_addr = 24'h000050;
        i_data_bus_rw = 1'b0;
        i_data_bus_enable = 1'b1;
        for (int k = 0; k <= 14; k++) begin
            @(posedge clk_166M66); #1;
            if (o_status_bus_transmitting) n_tx++;
            if (o_rdata_valid) n_vld++;
            if (k == 5) check("rwflip err set", 32'(o_bus_err), 32'(ERR_EN));
            if (k == 4) i_data_bus_rw = 1'b1;
            if (k == 5) i_data_bus_enable = 1'b0;
        end
        check("rwflip tx cycles", 32'(n_tx), 32'd6);
        check("rwflip valid pulses", 32'(n_vld), 32'd2);
        check("rwflip last rdata", o_rdata, 32'h5500_0051);
        check("rwflip err sticky", 32'(o_bus_err), 32'(ERR_EN));

        // Reset in the middle of beat 2 of a write, enable still high.
        i_addr = 24'h000040;
        i_data_bus_rw = 1'b1;
        i_wdata = 32'hC0;
        i_data_bus_enable = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            @(posedge clk_166M66); #1;
            if (k == 6) check("prerst addr", 32'(o_mem_addr), 32'h42);
            if (o_wdata_ready) i_wdata = i_wdata + 32'd1;
        end
        mcu_sys_rst = 1'b1;
        @(posedge clk_166M66); #1;
        check_zero("midrst");
        mcu_sys_rst = 1'b0;
        i_wdata = 32'hD0;
        @(posedge clk_166M66); #1;
        check("restart tx", 32'(o_status_bus_transmitting), 32'd1);
        check("restart addr", 32'(o_mem_addr), 32'h40);
        check("restart we", 32'(o_mem_we), 32'd1);
        check("restart wready", 32'(o_wdata_ready), 32'd1);
        check("restart mwdata", o_mem_wdata, 32'hD0);
        i_data_bus_enable = 1'b0;
        repeat (3) @(posedge clk_166M66);
        #1;
        check("restart end tx", 32'(o_status_bus_transmitting), 32'd0);
        check("restart mem", mem[8'h40], 32'hD0);
        repeat (3) @(posedge clk_166M66);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
